// File: rtl/minmax_tracker_pkg.sv
// minmax_pkg: shared definitions for the min/max tracker.
//   - FSM state encoding used by minmax_tracker
//   - default sample width and count/index field width
package minmax_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // no sample of the current frame seen yet
        ST_ACCUM = 2'd1,   // frame in progress
        ST_HOLD  = 2'd2    // frame result pending on the output port
    } state_e;

endpackage

// File: rtl/minmax_tracker_if.sv
// minmax_tracker_if: sample stream in, frame statistics out.
//   Input side : in_valid / in_ready / in_data / in_last
//   Output side: out_valid / out_ready / out_min / out_max /
//                out_min_idx / out_max_idx / out_count
//   master: the environment (producer of samples, consumer of results)
//   slave : the tracker
interface minmax_tracker_if
    import minmax_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_min;
    logic [WIDTH-1:0] out_max;
    logic [CNT_W-1:0] out_min_idx;
    logic [CNT_W-1:0] out_max_idx;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_min, out_max,
               out_min_idx, out_max_idx, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_min, out_max,
               out_min_idx, out_max_idx, out_count
    );

endinterface

// File: rtl/minmax_tracker_cmp.sv
// mag_compare: purely combinational unsigned magnitude comparator.
//   a, b : WIDTH-bit unsigned operands
//   gt   : a >  b
//   eq   : a == b
//   lt   : a <  b
module mag_compare #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (a >  b);
    assign eq = (a == b);
    assign lt = (a <  b);

endmodule

// File: rtl/minmax_tracker.sv
// minmax_tracker: per-frame minimum / maximum / first-occurrence index /
// sample count over a stream of unsigned samples framed by in_last.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clear : synchronous abort of the current frame and any pending result
//   bus   : sample input handshake and frame result output handshake
// Results are presented from the cycle after the in_last beat is accepted
// until the consumer takes them; no new sample is accepted while a result
// is pending.
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    minmax_tracker_if.slave    bus
);

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] min_q,     min_d;
    logic [WIDTH-1:0] max_q,     max_d;
    logic [CNT_W-1:0] min_idx_q, min_idx_d;
    logic [CNT_W-1:0] max_idx_q, max_idx_d;
    logic [CNT_W-1:0] count_q,   count_d;

    logic accept;
    logic min_gt, min_eq, min_lt;
    logic max_gt, max_eq, max_lt;

    // Sample count stops at all-ones; later extremes reuse that index.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    mag_compare #(.WIDTH(WIDTH)) u_cmp_min (
        .a  (bus.in_data),
        .b  (min_q),
        .gt (min_gt),
        .eq (min_eq),
        .lt (min_lt)
    );

    mag_compare #(.WIDTH(WIDTH)) u_cmp_max (
        .a  (bus.in_data),
        .b  (max_q),
        .gt (max_gt),
        .eq (max_eq),
        .lt (max_lt)
    );

    // Ties never move an extreme, so only the strict outputs are consumed.
    logic unused_cmp;
    assign unused_cmp = &{1'b0, min_gt, min_eq, max_eq, max_lt};

    // in_ready is deliberately independent of out_ready: the handshake
    // cycle of a pending result never also accepts a sample.
    assign bus.in_ready = !clear && (state_q != ST_HOLD);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        max_d     = max_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        count_d   = count_q;

        if (clear) begin
            state_d   = ST_EMPTY;
            min_d     = '0;
            max_d     = '0;
            min_idx_d = '0;
            max_idx_d = '0;
            count_d   = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        min_d     = bus.in_data;
                        max_d     = bus.in_data;
                        min_idx_d = '0;
                        max_idx_d = '0;
                        count_d   = CNT_W'(1);
                        state_d   = bus.in_last ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        // count_q is the 0-based index of the beat being accepted.
                        if (min_lt) begin
                            min_d     = bus.in_data;
                            min_idx_d = count_q;
                        end
                        if (max_gt) begin
                            max_d     = bus.in_data;
                            max_idx_d = count_q;
                        end
                        count_d = sat_inc(count_q);
                        if (bus.in_last) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            count_q   <= count_d;
        end
    end

    assign bus.out_valid   = (state_q == ST_HOLD);
    assign bus.out_min     = min_q;
    assign bus.out_max     = max_q;
    assign bus.out_min_idx = min_idx_q;
    assign bus.out_max_idx = max_idx_q;
    assign bus.out_count   = count_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// tb_minmax_tracker: scoreboard bench for minmax_tracker.
// Two instances: a full-width one (CNT_W=16) and one with CNT_W=2 to reach
// count saturation with a short frame.
module tb_minmax_tracker;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;

    always #5 clk = ~clk;

    minmax_tracker_if #(.WIDTH(16), .CNT_W(16)) bus  ();
    minmax_tracker_if #(.WIDTH(16), .CNT_W(2))  bus2 ();

    minmax_tracker #(.WIDTH(16), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    minmax_tracker #(.WIDTH(16), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus2)
    );

    typedef struct {
        int unsigned mn;
        int unsigned mx;
        int unsigned mn_i;
        int unsigned mx_i;
        int unsigned cnt;
    } res_t;

    typedef int unsigned uq_t[$];

    res_t exp_q[$];
    res_t exp2_q[$];
    res_t e1, e2;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: first-occurrence extremes, index and count limited to cmax.
    function automatic res_t model(input uq_t s, input int unsigned cmax);
        res_t        r;
        int unsigned idx;
        r = '{default: 0};
        for (int i = 0; i < s.size(); i++) begin
            idx = (int'(i) > int'(cmax)) ? cmax : int'(i);
            if (i == 0) begin
                r.mn = s[0];
                r.mx = s[0];
            end else begin
                if (s[i] < r.mn) begin
                    r.mn   = s[i];
                    r.mn_i = idx;
                end
                if (s[i] > r.mx) begin
                    r.mx   = s[i];
                    r.mx_i = idx;
                end
            end
        end
        r.cnt = (s.size() > int'(cmax)) ? cmax : s.size();
        return r;
    endfunction

    task automatic set_in(input int sel, input bit v, input int unsigned d, input bit last);
        if (sel == 0) begin
            bus.in_valid = v;
            bus.in_data  = d[15:0];
            bus.in_last  = last;
        end else begin
            bus2.in_valid = v;
            bus2.in_data  = d[15:0];
            bus2.in_last  = last;
        end
    endtask

    // Presents one beat until accepted; returns the number of stalled edges.
    task automatic drive_beat(input int sel, input int unsigned d, input bit last, output int stalls);
        bit done;
        bit rdy;
        done   = 1'b0;
        stalls = 0;
        while (!done) begin
            set_in(sel, 1'b1, d, last);
            @(negedge clk);
            rdy = (sel == 0) ? bus.in_ready : bus2.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 50) begin
                    check("accept_timeout", 0, 1);
                    done = 1'b1;
                end
            end
        end
        set_in(sel, 1'b0, 0, 1'b0);
    endtask

    task automatic send_frame(input int sel, input uq_t s, input bit push);
        int st;
        if (push) begin
            if (sel == 0) exp_q.push_back(model(s, 65535));
            else          exp2_q.push_back(model(s, 3));
        end
        for (int i = 0; i < s.size(); i++) begin
            drive_beat(sel, s[i], (i == s.size() - 1), st);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && !clear && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e1 = exp_q.pop_front();
                check("min",     bus.out_min,     e1.mn);
                check("max",     bus.out_max,     e1.mx);
                check("min_idx", bus.out_min_idx, e1.mn_i);
                check("max_idx", bus.out_max_idx, e1.mx_i);
                check("count",   bus.out_count,   e1.cnt);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && !clear && bus2.out_valid && bus2.out_ready) begin
            if (exp2_q.size() == 0) begin
                check("unexpected_result2", 1, 0);
            end else begin
                e2 = exp2_q.pop_front();
                check("min2",     bus2.out_min,     e2.mn);
                check("max2",     bus2.out_max,     e2.mx);
                check("min_idx2", bus2.out_min_idx, e2.mn_i);
                check("max_idx2", bus2.out_max_idx, e2.mx_i);
                check("count2",   bus2.out_count,   e2.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        uq_t s;
        int  st;

        rst_n = 1'b0;
        clear = 1'b0;
        set_in(0, 1'b0, 0, 1'b0);
        set_in(1, 1'b0, 0, 1'b0);
        bus.out_ready  = 1'b1;
        bus2.out_ready = 1'b1;

        // Reset state
        #1;
        check("rst_valid", bus.out_valid,   0);
        check("rst_min",   bus.out_min,     0);
        check("rst_max",   bus.out_max,     0);
        check("rst_count", bus.out_count,   0);
        check("rst_idx",   bus.out_max_idx, 0);
        #12;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", bus.in_ready, 1);

        // Basic frame, one-cycle result pulse
        s = '{25, 20, 30};
        send_frame(0, s, 1'b1);
        check("t1_valid_hi", bus.out_valid, 1);
        @(posedge clk); #1;
        check("t1_valid_lo", bus.out_valid, 0);

        // Ties keep first occurrence; single-beat frame
        s = '{50, 50, 50};
        send_frame(0, s, 1'b1);
        s = '{15};
        send_frame(0, s, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure with a held sample upstream
        bus.out_ready = 1'b0;
        s = '{40, 10};
        send_frame(0, s, 1'b1);
        s = '{99};
        exp_q.push_back(model(s, 65535));
        set_in(0, 1'b1, 99, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_ready_lo", bus.in_ready,  0);
            check("t3_valid_hi", bus.out_valid, 1);
            check("t3_min_hold", bus.out_min,   10);
            check("t3_max_hold", bus.out_max,   40);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drive_beat(0, 99, 1'b1, st);
        check("t3_stall", st, 1);
        repeat (2) @(posedge clk);
        #1;

        // Clear mid-frame; beat presented with clear is dropped
        drive_beat(0, 5, 1'b0, st);
        drive_beat(0, 60, 1'b0, st);
        clear = 1'b1;
        set_in(0, 1'b1, 1, 1'b1);
        @(negedge clk);
        check("t4_ready_clr", bus.in_ready, 0);
        @(posedge clk); #1;
        clear = 1'b0;
        set_in(0, 1'b0, 0, 1'b0);
        check("t4_min_clr",   bus.out_min,   0);
        check("t4_count_clr", bus.out_count, 0);
        check("t4_valid_clr", bus.out_valid, 0);
        s = '{7, 8};
        send_frame(0, s, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Clear while a result is pending, even with out_ready high
        bus.out_ready = 1'b0;
        s = '{3};
        send_frame(0, s, 1'b0);
        check("t4_hold_valid", bus.out_valid, 1);
        clear = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("t4_hold_drop", bus.out_valid, 0);
        check("t4_hold_min",  bus.out_min,   0);

        // Async reset mid-frame
        drive_beat(0, 70, 1'b0, st);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_min_async",   bus.out_min,   0);
        check("t5_max_async",   bus.out_max,   0);
        check("t5_count_async", bus.out_count, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t5_ready_rel", bus.in_ready,  1);
        check("t5_count_rel", bus.out_count, 0);

        // Async reset while holding a result
        bus.out_ready = 1'b0;
        s = '{80};
        send_frame(0, s, 1'b0);
        check("t5_hold_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_valid_async", bus.out_valid, 0);
        check("t5_max_async2",  bus.out_max,   0);
        #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("t5_ready_rel2", bus.in_ready,  1);
        check("t5_valid_rel2", bus.out_valid, 0);

        // Normal operation after reset
        s = '{300, 2, 300};
        send_frame(0, s, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Count saturation on the CNT_W=2 instance
        s = '{9, 8, 7, 6, 5, 4};
        send_frame(1, s, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        check("sb_empty",  exp_q.size(),  0);
        check("sb2_empty", exp2_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
